// File: rtl/mmio_loopback_monitor_if.sv
// Bus bundle for mmio_loopback_monitor: core MMIO buses plus the event drain port.
// The event_time signal exists only when MMIO_LOOPBACK_TIMESTAMP_EN is defined.
interface mmio_loopback_monitor_if #(
    parameter int CHANNELS = 8,
    parameter int WIDTH    = 32,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
);
    logic [CHANNELS-1:0][WIDTH-1:0] mmio_from_core;
    logic [CHANNELS-1:0][WIDTH-1:0] mmio_to_core;
    logic                           event_valid;
    logic                           event_ready;
    logic [CH_W-1:0]                event_channel;
    logic [WIDTH-1:0]               event_data;
    logic                           overflow;
    logic                           overflow_clear;
    logic [15:0]                    change_count;
`ifdef MMIO_LOOPBACK_TIMESTAMP_EN
    logic [31:0]                    event_time;
`endif

    // master = core/debug side, slave = the monitor itself
    modport master (
        output mmio_from_core, event_ready, overflow_clear,
        input  mmio_to_core, event_valid, event_channel, event_data, overflow, change_count
`ifdef MMIO_LOOPBACK_TIMESTAMP_EN
        , input event_time
`endif
    );

    modport slave (
        input  mmio_from_core, event_ready, overflow_clear,
        output mmio_to_core, event_valid, event_channel, event_data, overflow, change_count
`ifdef MMIO_LOOPBACK_TIMESTAMP_EN
        , output event_time
`endif
    );
endinterface

// File: rtl/mmio_loopback_monitor.sv
// MMIO loopback with configurable latency plus a change-event FIFO drained by valid/ready.
// Optional MMIO_LOOPBACK_TIMESTAMP_EN adds a 32-bit cycle stamp per event (event_time).
module mmio_loopback_monitor #(
    parameter int CHANNELS       = 8,
    parameter int WIDTH          = 32,
    parameter int LATENCY        = 1,
    parameter int FIFO_LOG_DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    mmio_loopback_monitor_if.slave bus
);
    localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int AW    = FIFO_LOG_DEPTH;
    localparam int DEPTH = 1 << FIFO_LOG_DEPTH;

    typedef struct packed {
`ifdef MMIO_LOOPBACK_TIMESTAMP_EN
        logic [31:0]      stamp;
`endif
        logic [CH_W-1:0]  channel;
        logic [WIDTH-1:0] data;
    } event_t;

    generate
        if (LATENCY == 0) begin : g_comb
            assign bus.mmio_to_core = bus.mmio_from_core;
        end else begin : g_pipe
            logic [CHANNELS-1:0][WIDTH-1:0] pipe_q [LATENCY];
            // NOTE: sequential state uses non-blocking (<=) so every stage samples the pre-edge value.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    for (int s = 0; s < LATENCY; s++) pipe_q[s] <= '0;
                end else begin
                    pipe_q[0] <= bus.mmio_from_core;
                    for (int s = 1; s < LATENCY; s++) pipe_q[s] <= pipe_q[s-1];
                end
            end
            assign bus.mmio_to_core = pipe_q[LATENCY-1];
        end
    endgenerate

    logic [CHANNELS-1:0][WIDTH-1:0] prev_q, hold_q, hold_d;
    logic [CHANNELS-1:0]            pending_q, pending_d, changed, granted;
`ifdef MMIO_LOOPBACK_TIMESTAMP_EN
    logic [CHANNELS-1:0][31:0]      stamp_q, stamp_d;
    logic [31:0]                    cycle_q;
`endif
    logic [AW:0]                    wr_q, rd_q;
    logic                           overflow_q;
    logic [15:0]                    count_q;
    logic                           found, push, pop, full, empty, lost;
    logic [CH_W-1:0]                sel;
    event_t                         push_ev, head_ev;
    event_t                         mem [DEPTH];

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign pop   = !empty && bus.event_ready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        sel       = '0;
        found     = 1'b0;
        lost      = 1'b0;
        pending_d = pending_q;
        hold_d    = hold_q;
        changed   = '0;
        granted   = '0;
`ifdef MMIO_LOOPBACK_TIMESTAMP_EN
        stamp_d   = stamp_q;
`endif
        // Descending scan leaves the lowest pending index selected.
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (pending_q[c]) begin
                sel   = CH_W'(c);
                found = 1'b1;
            end
        end
        push = found && (!full || pop);
        for (int c = 0; c < CHANNELS; c++) begin
            changed[c] = (bus.mmio_from_core[c] != prev_q[c]);
            granted[c] = push && (sel == CH_W'(c));
            if (granted[c]) pending_d[c] = 1'b0;
            if (changed[c]) begin
                if (pending_q[c] && !granted[c]) lost = 1'b1;
                pending_d[c] = 1'b1;
                hold_d[c]    = bus.mmio_from_core[c];
`ifdef MMIO_LOOPBACK_TIMESTAMP_EN
                stamp_d[c]   = cycle_q;
`endif
            end
        end
        push_ev.channel = sel;
        push_ev.data    = hold_q[sel];
`ifdef MMIO_LOOPBACK_TIMESTAMP_EN
        push_ev.stamp   = stamp_q[sel];
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_q     <= '0;
            hold_q     <= '0;
            pending_q  <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            overflow_q <= 1'b0;
            count_q    <= '0;
`ifdef MMIO_LOOPBACK_TIMESTAMP_EN
            stamp_q    <= '0;
            cycle_q    <= '0;
`endif
        end else begin
            prev_q    <= bus.mmio_from_core;
            hold_q    <= hold_d;
            pending_q <= pending_d;
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            // A loss in the same cycle as a clear request keeps the flag set.
            if (lost)                    overflow_q <= 1'b1;
            else if (bus.overflow_clear) overflow_q <= 1'b0;
            if (push && (count_q != 16'hFFFF)) count_q <= count_q + 16'd1;
`ifdef MMIO_LOOPBACK_TIMESTAMP_EN
            stamp_q   <= stamp_d;
            cycle_q   <= cycle_q + 32'd1;
`endif
        end
    end

    // NOTE: FIFO storage is not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clock) begin
        if (push) mem[wr_q[AW-1:0]] <= push_ev;
    end

    assign head_ev           = mem[rd_q[AW-1:0]];
    assign bus.event_valid   = !empty;
    assign bus.event_channel = head_ev.channel;
    assign bus.event_data    = head_ev.data;
    assign bus.overflow      = overflow_q;
    assign bus.change_count  = count_q;
`ifdef MMIO_LOOPBACK_TIMESTAMP_EN
    assign bus.event_time    = head_ev.stamp;
`endif
endmodule

// File: tb/tb_mmio_loopback_monitor.sv
// Directed bench: dut_a (32 ch, LATENCY=2, depth 16) and dut_b (8 ch, LATENCY=0).
// Builds with or without MMIO_LOOPBACK_TIMESTAMP_EN.
module tb_mmio_loopback_monitor;
    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    mmio_loopback_monitor_if #(.CHANNELS(32), .WIDTH(32)) bus_a ();
    mmio_loopback_monitor_if #(.CHANNELS(8),  .WIDTH(32)) bus_b ();

    mmio_loopback_monitor #(.CHANNELS(32), .WIDTH(32), .LATENCY(2), .FIFO_LOG_DEPTH(4))
        dut_a (.clock(clock), .reset(reset), .bus(bus_a));
    mmio_loopback_monitor #(.CHANNELS(8), .WIDTH(32), .LATENCY(0), .FIFO_LOG_DEPTH(4))
        dut_b (.clock(clock), .reset(reset), .bus(bus_b));

    typedef struct {
        int          ch;
        logic [31:0] val;
        logic [31:0] old;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          n_nz;
    logic [31:0] cur_a [32];
    int          exp_ch  [$];
    logic [31:0] exp_dat [$];
    vec_t        vecs [6];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic set_a(input int ch, input logic [31:0] val);
        bus_a.mmio_from_core[ch] = val;
        cur_a[ch] = val;
    endtask

    task automatic drain_a(input string name, input int budget);
        bus_a.event_ready = 1'b1;
        for (int i = 0; i < budget && exp_ch.size() > 0; i++) begin
            if (bus_a.event_valid) begin
                check({name, " ch"},   64'(bus_a.event_channel), 64'(exp_ch.pop_front()));
                check({name, " data"}, 64'(bus_a.event_data),    64'(exp_dat.pop_front()));
            end
            step();
        end
        check({name, " left"}, 64'(exp_ch.size()), 64'd0);
        exp_ch.delete();
        exp_dat.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{3,  32'hDEADBEEF, 32'h0};
        vecs[1] = '{0,  32'h00000001, 32'h0};
        vecs[2] = '{31, 32'hFFFFFFFF, 32'h0};
        vecs[3] = '{3,  32'h00000000, 32'hDEADBEEF};
        vecs[4] = '{17, 32'h12345678, 32'h0};
        vecs[5] = '{0,  32'h00000002, 32'h1};

        for (int c = 0; c < 32; c++) cur_a[c] = '0;
        bus_a.mmio_from_core = '0;
        bus_b.mmio_from_core = '0;
        bus_a.event_ready    = 1'b1;
        bus_b.event_ready    = 1'b1;
        bus_a.overflow_clear = 1'b0;
        bus_b.overflow_clear = 1'b0;

        #12;
        check("reset valid",    64'(bus_a.event_valid),   64'd0);
        check("reset count",    64'(bus_a.change_count),  64'd0);
        check("reset overflow", 64'(bus_a.overflow),      64'd0);
        check("reset to_core",  64'(|bus_a.mmio_to_core), 64'd0);
        reset = 1'b1;
        step();

        // Single-channel events through the LATENCY=2 loopback
        for (int i = 0; i < 6; i++) begin
            set_a(vecs[i].ch, vecs[i].val);
            step();
            check("vec loop k+1",  64'(bus_a.mmio_to_core[vecs[i].ch]), 64'(vecs[i].old));
            check("vec valid k+1", 64'(bus_a.event_valid), 64'd0);
            step();
            check("vec loop k+2",  64'(bus_a.mmio_to_core[vecs[i].ch]), 64'(vecs[i].val));
            check("vec valid k+2", 64'(bus_a.event_valid), 64'd1);
            check("vec ch",        64'(bus_a.event_channel), 64'(vecs[i].ch));
            check("vec data",      64'(bus_a.event_data), 64'(vecs[i].val));
            check("vec count",     64'(bus_a.change_count), 64'(i + 1));
            step();
            check("vec popped",    64'(bus_a.event_valid), 64'd0);
        end

        // LATENCY=0 loopback is combinational
        bus_b.mmio_from_core[3] = 32'hDEADBEEF;
        #1;
        check("lat0 ch3", 64'(bus_b.mmio_to_core[3]), 64'hDEADBEEF);
        check("lat0 ch4", 64'(bus_b.mmio_to_core[4]), 64'h0);
        step();

        // Simultaneous changes pop in index order
        set_a(5, 32'h55);
        set_a(1, 32'h11);
        set_a(6, 32'h66);
        step();
        check("sim valid k+1", 64'(bus_a.event_valid), 64'd0);
        step();
        check("sim ch1", 64'(bus_a.event_channel), 64'd1);
        check("sim d1",  64'(bus_a.event_data), 64'h11);
        step();
        check("sim ch5", 64'(bus_a.event_channel), 64'd5);
        check("sim d5",  64'(bus_a.event_data), 64'h55);
        step();
        check("sim ch6", 64'(bus_a.event_channel), 64'd6);
        check("sim d6",  64'(bus_a.event_data), 64'h66);
        check("sim count", 64'(bus_a.change_count), 64'd9);
        step();
        check("sim empty", 64'(bus_a.event_valid), 64'd0);

        // Back-pressure: 16 queued, 4 pending
        bus_a.event_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            set_a(i, 32'hA000 + 32'(i));
            step();
            step();
        end
        step();
        step();
        check("full valid",    64'(bus_a.event_valid),  64'd1);
        check("full overflow", 64'(bus_a.overflow),     64'd0);
        check("full count",    64'(bus_a.change_count), 64'd25);
        check("full head ch",  64'(bus_a.event_channel), 64'd0);
        step();
        check("full head stable", 64'(bus_a.event_data), 64'hA000);
        for (int i = 0; i < 20; i++) begin
            exp_ch.push_back(i);
            exp_dat.push_back(32'hA000 + 32'(i));
        end
        drain_a("full drain", 60);
        check("full count end", 64'(bus_a.change_count), 64'd29);

        // Overflow on a pending channel while full; set beats clear
        bus_a.event_ready = 1'b0;
        for (int i = 8; i < 24; i++) begin
            set_a(i, 32'hB000 + 32'(i));
            step();
            step();
        end
        check("ovf count full", 64'(bus_a.change_count), 64'd45);
        set_a(2, 32'h1);
        step();
        set_a(2, 32'h2);
        bus_a.overflow_clear = 1'b1;
        check("ovf before", 64'(bus_a.overflow), 64'd0);
        step();
        bus_a.overflow_clear = 1'b0;
        check("ovf set wins", 64'(bus_a.overflow), 64'd1);
        step();
        check("ovf sticky", 64'(bus_a.overflow), 64'd1);
        bus_a.overflow_clear = 1'b1;
        step();
        bus_a.overflow_clear = 1'b0;
        check("ovf cleared", 64'(bus_a.overflow), 64'd0);
        for (int i = 8; i < 24; i++) begin
            exp_ch.push_back(i);
            exp_dat.push_back(32'hB000 + 32'(i));
        end
        exp_ch.push_back(2);
        exp_dat.push_back(32'h2);
        drain_a("ovf drain", 60);
        check("ovf count end", 64'(bus_a.change_count), 64'd46);

        // Async reset with queued events
        bus_a.event_ready = 1'b0;
        for (int i = 24; i < 29; i++) set_a(i, 32'hC000 + 32'(i));
        for (int i = 0; i < 8; i++) step();
        check("pre-rst count", 64'(bus_a.change_count), 64'd51);
        check("pre-rst valid", 64'(bus_a.event_valid),  64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("rst valid",   64'(bus_a.event_valid),   64'd0);
        check("rst count",   64'(bus_a.change_count),  64'd0);
        check("rst to_core", 64'(|bus_a.mmio_to_core), 64'd0);
        #1;
        reset = 1'b1;
        cyc = 0;
        n_nz = 0;
        for (int c = 0; c < 32; c++) begin
            if (cur_a[c] != 32'h0) begin
                exp_ch.push_back(c);
                exp_dat.push_back(cur_a[c]);
                n_nz++;
            end
        end
        drain_a("post-rst drain", 60);
        step();
        step();
        check("post-rst no extra", 64'(bus_a.event_valid),  64'd0);
        check("post-rst count",    64'(bus_a.change_count), 64'(n_nz));

        // Event on dut_b at counter value 100
        while (cyc < 100) step();
        bus_b.mmio_from_core[0] = 32'h77;
        step();
        step();
        check("ts valid", 64'(bus_b.event_valid),   64'd1);
        check("ts ch",    64'(bus_b.event_channel), 64'd0);
        check("ts data",  64'(bus_b.event_data),    64'h77);
`ifdef MMIO_LOOPBACK_TIMESTAMP_EN
        check("ts time",  64'(bus_b.event_time),    64'd100);
`endif
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
